// File: rtl/usb_rx_bit_decoder.sv
// USB full-speed receive bit decoder: sync, bit recovery, NRZI decode, unstuff, byte assembly, EOP.
// Optional stuff-error flag is built when USB_STUFF_ERR_EN is defined.
module usb_rx_bit_decoder #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_PT    = 3
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_plus,
    input  logic       d_minus,
    output logic       d_edge,
    output logic       shift_enable,
    output logic [7:0] rcv_data,
    output logic       byte_received,
    output logic       eop
`ifdef USB_STUFF_ERR_EN
   ,output logic       stuff_error
`endif
);

    // state    | meaning
    // IDLE     | bus idle, waiting for first transition of a packet
    // RX       | sampling bits, decoding and assembling bytes
    // EOP_WAIT | SE0 seen, waiting for J to close the packet
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RX       = 2'd1,
        ST_EOP_WAIT = 2'd2
    } state_t;

    localparam int            TW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] C_LAST   = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] C_SAMPLE = TW'(SAMPLE_PT);

    logic          r_dp_s1, r_dp_s2, r_dm_s1, r_dm_s2, r_dp_d;
    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic          r_prev;
    logic [2:0]    r_ones;
    logic [2:0]    r_bit_cnt;
    logic [6:0]    r_shift;
    logic [7:0]    r_rcv_data;
    logic          r_byte_rx;
    logic          r_eop;
`ifdef USB_STUFF_ERR_EN
    logic          r_stuff_err;
`endif

    logic       w_edge, w_sample, w_se0, w_j, w_bit, w_stuffed, w_valid;
    logic [7:0] w_next;

    // Line resets to idle J so no spurious edge follows reset release.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_dp_s1 <= 1'b1;
            r_dp_s2 <= 1'b1;
            r_dm_s1 <= 1'b0;
            r_dm_s2 <= 1'b0;
            r_dp_d  <= 1'b1;
        end else begin
            r_dp_s1 <= d_plus;
            r_dp_s2 <= r_dp_s1;
            r_dm_s1 <= d_minus;
            r_dm_s2 <= r_dm_s1;
            r_dp_d  <= r_dp_s2;
        end
    end

    assign w_edge    = r_dp_s2 ^ r_dp_d;
    // A resync edge suppresses the sample that would coincide with it.
    assign w_sample  = (r_state != ST_IDLE) && (r_timer == C_SAMPLE) && !w_edge;
    assign w_se0     = !r_dp_s2 && !r_dm_s2;
    assign w_j       = r_dp_s2 && !r_dm_s2;
    assign w_bit     = (r_dp_s2 == r_prev);
    assign w_stuffed = (r_ones == 3'd6) && !w_bit;
    assign w_valid   = w_sample && (r_state == ST_RX) && !w_se0 && !w_stuffed;
    assign w_next    = {w_bit, r_shift};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_prev     <= 1'b1;
            r_ones     <= 3'd0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 7'd0;
            r_rcv_data <= 8'h00;
            r_byte_rx  <= 1'b0;
            r_eop      <= 1'b0;
`ifdef USB_STUFF_ERR_EN
            r_stuff_err <= 1'b0;
`endif
        end else begin
            r_byte_rx <= 1'b0;

            if (r_state == ST_IDLE || w_edge || r_timer == C_LAST)
                r_timer <= '0;
            else
                r_timer <= r_timer + TW'(1);

            case (r_state)
                ST_IDLE: begin
                    if (w_edge) begin
                        r_state   <= ST_RX;
                        r_bit_cnt <= 3'd0;
                        r_ones    <= 3'd0;
                    end
                end
                ST_RX: begin
                    if (w_sample) begin
                        if (w_se0) begin
                            r_state   <= ST_EOP_WAIT;
                            r_eop     <= 1'b1;
                            r_bit_cnt <= 3'd0;
                            r_ones    <= 3'd0;
                        end else begin
                            r_prev <= r_dp_s2;
                            if (w_stuffed) begin
                                r_ones <= 3'd0;
                            end else begin
                                if (!w_bit)
                                    r_ones <= 3'd0;
                                else if (r_ones != 3'd7)
                                    r_ones <= r_ones + 3'd1;
`ifdef USB_STUFF_ERR_EN
                                if (w_bit && r_ones == 3'd6)
                                    r_stuff_err <= 1'b1;
`endif
                                r_shift <= w_next[7:1];
                                if (r_bit_cnt == 3'd7) begin
                                    r_rcv_data <= w_next;
                                    r_byte_rx  <= 1'b1;
                                    r_bit_cnt  <= 3'd0;
                                end else begin
                                    r_bit_cnt <= r_bit_cnt + 3'd1;
                                end
                            end
                        end
                    end
                end
                ST_EOP_WAIT: begin
                    if (w_sample && w_j) begin
                        r_state <= ST_IDLE;
                        r_eop   <= 1'b0;
                        r_prev  <= 1'b1;
`ifdef USB_STUFF_ERR_EN
                        r_stuff_err <= 1'b0;
`endif
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign d_edge        = w_edge;
    assign shift_enable  = w_valid;
    assign rcv_data      = r_rcv_data;
    assign byte_received = r_byte_rx;
    assign eop           = r_eop;
`ifdef USB_STUFF_ERR_EN
    assign stuff_error   = r_stuff_err;
`endif

endmodule

// File: tb/tb_usb_rx_bit_decoder.sv
// Directed bench for usb_rx_bit_decoder: drives NRZI packets on D+/D- and checks decoded output.
module tb_usb_rx_bit_decoder;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       d_plus = 1'b1;
    logic       d_minus = 1'b0;
    logic       d_edge, shift_enable, byte_received, eop;
    logic [7:0] rcv_data;
`ifdef USB_STUFF_ERR_EN
    logic       stuff_error;
`endif

    usb_rx_bit_decoder dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .d_plus       (d_plus),
        .d_minus      (d_minus),
        .d_edge       (d_edge),
        .shift_enable (shift_enable),
        .rcv_data     (rcv_data),
        .byte_received(byte_received),
        .eop          (eop)
`ifdef USB_STUFF_ERR_EN
       ,.stuff_error  (stuff_error)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    int         se_cnt = 0;
    int         br_cnt = 0;
    int         de_cnt = 0;
    logic [7:0] last_byte = 8'h00;

    always @(negedge clk) begin
        if (shift_enable)  se_cnt <= se_cnt + 1;
        if (d_edge)        de_cnt <= de_cnt + 1;
        if (byte_received) begin
            br_cnt    <= br_cnt + 1;
            last_byte <= rcv_data;
        end
    end

    logic line = 1'b1;
    int   b_ones = 0;
    bit   stuff_on = 1'b0;
    int   s0, b0, e0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic lvl, input int n);
        d_plus  = lvl;
        d_minus = ~lvl;
        repeat (n) @(negedge clk);
    endtask

    // Transmitter model: 0 toggles the line, 1 holds it; optional stuffing after six 1s.
    task automatic send_bit(input bit b, input int n);
        if (!b) line = ~line;
        drive(line, n);
        if (b) b_ones++; else b_ones = 0;
        if (stuff_on && b_ones == 6) begin
            line = ~line;
            drive(line, 8);
            b_ones = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input int n_even, input int n_odd);
        for (int i = 0; i < 8; i++) send_bit(v[i], (i % 2 == 0) ? n_even : n_odd);
    endtask

    task automatic send_sync();
        b_ones = 0;
        send_byte(8'h80, 8, 8);
    endtask

    task automatic end_packet();
        d_plus  = 1'b0;
        d_minus = 1'b0;
        repeat (16) @(negedge clk);
        line = 1'b1;
        drive(1'b1, 24);
    endtask

    task automatic mark();
        s0 = se_cnt;
        b0 = br_cnt;
        e0 = de_cnt;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_d_edge", d_edge, 1'b0);
        check("rst_shift_en", shift_enable, 1'b0);
        check("rst_byte_rx", byte_received, 1'b0);
        check("rst_eop", eop, 1'b0);
        check("rst_rcv_data", rcv_data, 8'h00);
`ifdef USB_STUFF_ERR_EN
        check("rst_stuff_err", stuff_error, 1'b0);
`endif
        n_rst = 1'b1;
        repeat (8) @(negedge clk);
        check("idle_no_edge", de_cnt, 0);

        // 1: sync pattern alone, then EOP with level checks
        mark();
        send_sync();
        check("t1_eop_before", eop, 1'b0);
        d_plus  = 1'b0;
        d_minus = 1'b0;
        repeat (8) @(negedge clk);
        check("t1_eop_se0_1", eop, 1'b1);
        repeat (8) @(negedge clk);
        check("t1_eop_se0_2", eop, 1'b1);
        check("t1_shift_cnt", se_cnt - s0, 8);
        check("t1_byte_cnt", br_cnt - b0, 1);
        check("t1_byte", last_byte, 8'h80);
        check("t1_rcv_data", rcv_data, 8'h80);
        line = 1'b1;
        drive(1'b1, 8);
        check("t1_eop_after_j", eop, 1'b0);
        drive(1'b1, 16);
        check("t1_no_shift_eop", se_cnt - s0, 8);

        // 3: new packet after EOP decodes cleanly
        mark();
        send_sync();
        check("t3_edges", de_cnt - e0, 7);
        end_packet();
        check("t3_shift_cnt", se_cnt - s0, 8);
        check("t3_byte_cnt", br_cnt - b0, 1);
        check("t3_byte", last_byte, 8'h80);

        // 2: 8'hFF with a stuffed zero
        stuff_on = 1'b1;
        mark();
        send_sync();
        send_byte(8'hFF, 8, 8);
`ifdef USB_STUFF_ERR_EN
        check("t2_stuff_err", stuff_error, 1'b0);
`endif
        end_packet();
        stuff_on = 1'b0;
        check("t2_shift_cnt", se_cnt - s0, 16);
        check("t2_byte_cnt", br_cnt - b0, 2);
        check("t2_byte", last_byte, 8'hFF);

        // 4: jittered 7/9-clock bit periods
        mark();
        send_sync();
        send_byte(8'hA5, 7, 9);
        end_packet();
        check("t4_shift_cnt", se_cnt - s0, 16);
        check("t4_byte_cnt", br_cnt - b0, 2);
        check("t4_byte", last_byte, 8'hA5);
        check("t4_eop_low", eop, 1'b0);

        // 5: reset mid-byte, then clean byte
        send_sync();
        for (int i = 0; i < 4; i++) send_bit(i[0], 8);
        n_rst   = 1'b0;
        line    = 1'b1;
        d_plus  = 1'b1;
        d_minus = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_rst_rcv_data", rcv_data, 8'h00);
        check("t5_rst_shift_en", shift_enable, 1'b0);
        check("t5_rst_byte_rx", byte_received, 1'b0);
        check("t5_rst_eop", eop, 1'b0);
        n_rst = 1'b1;
        repeat (16) @(negedge clk);
        mark();
        send_sync();
        send_byte(8'h3C, 8, 8);
        end_packet();
        check("t5_shift_cnt", se_cnt - s0, 16);
        check("t5_byte_cnt", br_cnt - b0, 2);
        check("t5_byte", last_byte, 8'h3C);

        // 6: unstuffed run of 1s across two bytes
        mark();
        send_sync();
        send_byte(8'hFF, 8, 8);
        send_byte(8'hFF, 8, 8);
        check("t6_shift_cnt", se_cnt - s0, 24);
        check("t6_byte_cnt", br_cnt - b0, 3);
        check("t6_byte", last_byte, 8'hFF);
`ifdef USB_STUFF_ERR_EN
        check("t6_stuff_err_set", stuff_error, 1'b1);
`endif
        end_packet();
`ifdef USB_STUFF_ERR_EN
        check("t6_stuff_err_clr", stuff_error, 1'b0);
`endif
        check("t6_eop_low", eop, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
